// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator-side front end for the single-port scratch memory. Accepts one
// read/write request at a time over a valid/ready handshake, drives the
// memory pins for WAIT_STATES+1 ACCESS cycles, and returns one response per
// request over a second valid/ready handshake. The memory commits writes on
// the falling clock edge and returns read data combinationally.
//
// Parameters
//   ADDR_W       memory address width
//   DATA_W       memory data width
//   WAIT_STATES  extra ACCESS cycles before sampling/committing (0..15)
//
// Ports
//   clk, rst_n         clock (rising edge) and async active-low reset
//   req_valid/ready    request handshake
//   req_we/addr/wdata  request payload (sampled only on the IDLE accept edge)
//   resp_valid/ready   response handshake
//   resp_we/rdata      response payload (rdata echoes wdata for writes)
//   mem_write_enable   to memory write_enable (high in last ACCESS cycle of a write)
//   mem_address        to memory address (holds last value outside ACCESS)
//   mem_write_data     to memory write_data (holds last value outside ACCESS)
//   mem_read_data      from memory read_data (combinational)
//
// Optional feature (macro MEM_ACCESS_CTRL_STATS_EN)
//   stat_rd_cnt, stat_wr_cnt  saturating 16-bit completed read/write counters
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_ACCESS_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [3:0]          r_wait_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_resp_we;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic                w_accept;
    logic                w_access_done;

    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_access_done = (r_state == ACCESS) && (r_wait_cnt == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid)     w_next_state = ACCESS;
            ACCESS:  if (w_access_done) w_next_state = RESP;
            RESP:    if (resp_ready)    w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // The state register sits in IDLE during reset, so req_ready is gated
        // by rst_n to keep it low while reset is held yet high immediately
        // after release.
        req_ready        = rst_n && (r_state == IDLE);
        resp_valid       = (r_state == RESP);
        // Only the final ACCESS cycle of a write drives the enable, so exactly
        // one falling edge commits it; async reset forces IDLE and drops it.
        mem_write_enable = w_access_done && r_we;
    end

    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign resp_we        = r_resp_we;
    assign resp_rdata     = r_resp_rdata;

    // -------------------------------------------------------------------------
    // Request capture, wait counter and response capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_we    <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_wait_cnt <= WAIT_INIT;
            end
            if (r_state == ACCESS) begin
                if (r_wait_cnt != '0) begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end else begin
                    r_resp_we    <= r_we;
                    r_resp_rdata <= r_we ? r_wdata : mem_read_data;
                end
            end
        end
    end

`ifdef MEM_ACCESS_CTRL_STATS_EN
    // -------------------------------------------------------------------------
    // Completed-access counters, bumped on ACCESS -> RESP, saturating
    // -------------------------------------------------------------------------
    logic [15:0] r_stat_rd_cnt;
    logic [15:0] r_stat_wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rd_cnt <= '0;
            r_stat_wr_cnt <= '0;
        end else if (w_access_done) begin
            if (r_we) begin
                if (r_stat_wr_cnt != '1) r_stat_wr_cnt <= r_stat_wr_cnt + 16'd1;
            end else begin
                if (r_stat_rd_cnt != '1) r_stat_rd_cnt <= r_stat_rd_cnt + 16'd1;
            end
        end
    end

    assign stat_rd_cnt = r_stat_rd_cnt;
    assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side front end for the single-port scratch memory. It accepts read/write requests from the datapath over a valid/ready handshake and drives the memory's write-enable, address and write-data pins. The memory writes on the falling clock edge and reads combinationally. The block samples read data and returns one response per request over a second valid/ready handshake. It sits between the control FSM and the memory and serialises all accesses: one outstanding request at a time.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 8, memory data width
WAIT_STATES, 0, extra ACCESS cycles before sampling or committing; legal range 0..15

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data; ignored for reads
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_we  output  1  echoes req_we of the completed request
resp_rdata  output  DATA_W  read data; echoes write data for writes
mem_write_enable  output  1  to memory write_enable
mem_address  output  ADDR_W  to memory address
mem_write_data  output  DATA_W  to memory write_data
mem_read_data  input  DATA_W  from memory read_data (combinational)

Behaviour:
- Reset is asynchronous and active-low: clock `clk`, reset `rst_n`. On assertion, state goes to IDLE and every output is 0: req_ready, resp_valid, resp_we, resp_rdata, mem_write_enable, mem_address, mem_write_data.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - Rising edge with req_valid=1 registers we/addr/wdata, loads wait_cnt = WAIT_STATES, and moves to ACCESS.
- ACCESS:
  - req_ready = 0; mem_address and mem_write_data driven from the registered request.
  - mem_write_enable = 1 only when the request is a write and wait_cnt == 0. Exactly one falling edge commits each write.
  - While wait_cnt != 0: decrement.
  - At the edge where wait_cnt == 0: move to RESP. For a read, capture mem_read_data into resp_rdata. For a write, load resp_rdata with wdata. Load resp_we.
  - ACCESS lasts WAIT_STATES+1 cycles.
- RESP:
  - resp_valid = 1; resp_we and resp_rdata hold stable until the handshake.
  - On resp_ready=1 at a rising edge, return to IDLE. req_ready is high in the following cycle; a request cannot be accepted in the same cycle the response is accepted.
- Latency: request accepted at edge N, resp_valid high from edge N+WAIT_STATES+1. Minimum request-to-request throughput is WAIT_STATES+3 cycles.
- In IDLE and RESP:
  - mem_write_enable = 0.
  - mem_address and mem_write_data keep their last values; they are not re-driven to 0.
- req_* signals are don't-care outside the IDLE accept cycle.
- Back-to-back access to the same address: the read after a write returns the new data, because the write committed on the falling edge inside ACCESS.
- Reset mid-ACCESS: mem_write_enable drops immediately (asynchronous), so a write not yet committed at its falling edge is dropped. No response is produced for it.
- Reset mid-RESP: the pending response is discarded.
- Address width is passed straight through; no range checking.

Optional Feature:
- Macro MEM_ACCESS_CTRL_STATS_EN.
- When defined, two extra output ports exist:
  - stat_rd_cnt [15:0]: reads completed.
  - stat_wr_cnt [15:0]: writes completed.
- Each counter increments on the ACCESS to RESP transition, saturates at 16'hFFFF, and resets to 0.
- When the macro is undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset with req_valid=1 held: all outputs 0 while rst_n=0. After release, req_ready=1, and the first accept occurs at the first rising edge.
- WAIT_STATES=0, write addr 5'd3 data 8'hA5, then read addr 3:
  - Write: mem_write_enable high for exactly 1 cycle; resp_we=1, resp_rdata=8'hA5.
  - Read: resp_rdata=8'hA5, resp_we=0.
  - resp_valid appears 1 cycle after each accept.
- WAIT_STATES=3, read addr 5'd31 after writing 8'h5A there: resp_valid appears 4 cycles after the accept; resp_rdata=8'h5A; mem_write_enable stays 0 throughout the read.
- Response backpressure: hold resp_ready=0 for 5 cycles after a read of 8'h3C. resp_valid stays 1, resp_rdata stays 8'h3C, req_ready stays 0. Raise resp_ready: IDLE on the next cycle.
- Reset mid-write: assert rst_n=0 during ACCESS with WAIT_STATES=2, before wait_cnt reaches 0. Required: no memory write occurs (a later read returns the old value) and no response is produced.
- With MEM_ACCESS_CTRL_STATS_EN: 3 writes and 2 reads give stat_wr_cnt=3 and stat_rd_cnt=2; a reset clears both to 0.
